spmv_csr_engine: RTL

- Parametrised CSR sparse matrix-vector multiply-accumulate engine; successor to the fixed 16-row SpMV ops block.
- Consumes a streamed sequence of (A nonzero, gathered x[col]) operand pairs against a row-pointer vector and accumulates one dot product per row into a result register file.
- Adds a valid/ready handshake, start/done control, empty-row skipping, a pipelined multiplier, selectable saturating or wrapping accumulation, and malformed-pointer detection.
- Sits between the operand fetch unit (A values plus B gather) and the result writeback.

---
 rtl/spmv_pkg.sv | 27 ++
 rtl/spmv_fx_mac.sv | 57 +++++
 rtl/spmv_csr_engine.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/spmv_pkg.sv
// Shared types and constants for the CSR SpMV engine: FSM encoding, default widths, clamp limits.
package spmv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SKIP,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DEF_NUM_ROWS = 16;
    localparam int DEF_PTR_W    = 8;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_FRAC_W   = 8;
    localparam bit DEF_SATURATE = 1'b1;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/spmv_fx_mac.sv
// One fixed-point MAC lane: registered product + row tag (1 cycle), then a combinational
// shift-and-add against the caller's accumulator with clamp or wrap; no backpressure.
module spmv_fx_mac
    import spmv_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter bit SATURATE = DEF_SATURATE,
    parameter int TAG_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] acc,
    output logic              out_vld,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] sum
);
    localparam int PROD_W = 2 * DATA_W;
    // Wide enough to hold any shifted product plus the accumulator without loss.
    localparam int ACC_W  = PROD_W - FRAC_W + 1;
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(DATA_W));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(DATA_W));

    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  wide;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_tag <= '0;
            prod_q  <= '0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                prod_q  <= PROD_W'($signed(a)) * PROD_W'($signed(b));
                out_tag <= in_tag;
            end
        end
    end

    always_comb begin
        wide = ACC_W'(prod_q >>> FRAC_W) + ACC_W'($signed(acc));
        sum  = wide[DATA_W-1:0];
        if (SATURATE) begin
            if (wide > MAX_V) begin
                sum = MAX_V[DATA_W-1:0];
            end else if (wide < MIN_V) begin
                sum = MIN_V[DATA_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spmv_csr_engine.sv
// CSR SpMV engine: accumulates streamed (A, x[col]) pairs into one result per row; o_done 3 cycles
// after the last transfer. o_ready is high only in RUN; the source holds i_valid data otherwise.
module spmv_csr_engine
    import spmv_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int PTR_W    = DEF_PTR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter bit SATURATE = DEF_SATURATE
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [(NUM_ROWS+1)*PTR_W-1:0] i_row_ptr,
    input  logic                          i_valid,
    input  logic [DATA_W-1:0]             i_data_A,
    input  logic [DATA_W-1:0]             i_data_B,
    output logic                          o_ready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err,
    output logic [NUM_ROWS*DATA_W-1:0]    o_result
);
    localparam int ROW_W = $clog2(NUM_ROWS + 1);
    localparam int TAG_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  ptr_q [NUM_ROWS+1];
    logic [DATA_W-1:0] res_q [NUM_ROWS];
    logic [ROW_W-1:0]  row, row_nxt, row_p1;
    logic [PTR_W-1:0]  cnt, cnt_nxt, cnt_p1, nxt_ptr, last_ptr;
    logic              start_ok, xfer, malformed, err_q, done_q;
    logic              mac_vld;
    logic [TAG_W-1:0]  mac_tag;
    logic [DATA_W-1:0] mac_sum;

    assign start_ok = i_start && (state == ST_IDLE || state == ST_DONE);
    assign o_ready  = (state == ST_RUN);
    assign o_busy   = state inside {ST_LOAD, ST_SKIP, ST_RUN, ST_DRAIN};
    assign xfer     = i_valid && o_ready;
    assign row_p1   = row + ROW_W'(1);
    assign cnt_p1   = cnt + PTR_W'(1);
    assign nxt_ptr  = ptr_q[row_p1];
    assign last_ptr = ptr_q[NUM_ROWS];
    assign o_done   = done_q;
    assign o_err    = err_q;

    always_comb begin
        malformed = (ptr_q[0] != '0);
        for (int k = 0; k < NUM_ROWS; k++) begin
            if (ptr_q[k+1] < ptr_q[k]) malformed = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE:  if (i_start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                row_nxt = '0;
                cnt_nxt = '0;
                if (malformed || last_ptr == '0) state_nxt = ST_DONE;
                else                             state_nxt = ST_SKIP;
            end
            // A row whose end pointer equals the running count has no more nonzeros.
            ST_SKIP: begin
                if (nxt_ptr == cnt) row_nxt = row_p1;
                else                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (xfer) begin
                    cnt_nxt = cnt_p1;
                    if (cnt_p1 == last_ptr) begin
                        state_nxt = ST_DRAIN;
                    end else if (cnt_p1 == nxt_ptr) begin
                        row_nxt   = row_p1;
                        state_nxt = ST_SKIP;
                    end
                end
            end
            ST_DRAIN: if (!mac_vld) state_nxt = ST_DONE;
            ST_DONE:  if (i_start) state_nxt = ST_LOAD;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            row    <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            for (int k = 0; k <= NUM_ROWS; k++) ptr_q[k] <= '0;
        end else begin
            state  <= state_nxt;
            row    <= row_nxt;
            cnt    <= cnt_nxt;
            done_q <= (state_nxt == ST_DONE) && (state != ST_DONE);
            if (start_ok) begin
                err_q <= 1'b0;
                for (int k = 0; k <= NUM_ROWS; k++) ptr_q[k] <= i_row_ptr[k*PTR_W +: PTR_W];
            end else if (state == ST_LOAD) begin
                err_q <= malformed;
            end
        end
    end

    spmv_fx_mac #(
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .SATURATE (SATURATE),
        .TAG_W    (TAG_W)
    ) u_mac (
        .clk     (i_clk),
        .rst     (i_rst),
        .in_vld  (xfer),
        .a       (i_data_A),
        .b       (i_data_B),
        .in_tag  (row[TAG_W-1:0]),
        .acc     (res_q[mac_tag]),
        .out_vld (mac_vld),
        .out_tag (mac_tag),
        .sum     (mac_sum)
    );

    // Read-modify-write in one cycle, so back-to-back hits on the same row see the prior sum.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < NUM_ROWS; r++) res_q[r] <= '0;
        end else if (state == ST_LOAD) begin
            for (int r = 0; r < NUM_ROWS; r++) res_q[r] <= '0;
        end else if (mac_vld) begin
            res_q[mac_tag] <= mac_sum;
        end
    end

    always_comb begin
        o_result = '0;
        for (int r = 0; r < NUM_ROWS; r++) o_result[r*DATA_W +: DATA_W] = res_q[r];
    end

endmodule
